maze_map_ctrl: RTL and testbench

- Sequences all writes into the 4x5 maze tile store that feeds the VGA pixel logic.
- Accepts decoded 16-bit robot packets from the radio receiver path using a valid/ready handshake.
- Validates packets, suppresses repeats and translates tile type to palette colour.
- Also handles the grid-initialisation sweep, automatic demotion of the previous "current" tile to visited, and treasure/error bookkeeping.

---
 rtl/maze_pkg.sv | 48 ++++
 rtl/maze_type_decode.sv | 40 ++++
 rtl/maze_map_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_maze_map_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// ============================================================================
// maze_pkg : shared constants, packet layout, palette and FSM states for the
//            maze tile-store write controller.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package maze_pkg;

   localparam int c_grid_w_def = 4;
   localparam int c_grid_h_def = 5;

   // Bit positions (LSB) of the fields inside a 16-bit robot packet.
   localparam int c_pkt_x_lsb = 14;
   localparam int c_pkt_y_lsb = 11;
   localparam int c_pkt_t_lsb = 8;
   localparam int c_pkt_w_lsb = 4;

   localparam logic [2:0] c_t_unvisited  = 3'd0;
   localparam logic [2:0] c_t_visited    = 3'd1;
   localparam logic [2:0] c_t_wall       = 3'd2;
   localparam logic [2:0] c_t_treasure7  = 3'd3;
   localparam logic [2:0] c_t_treasure12 = 3'd4;
   localparam logic [2:0] c_t_treasure17 = 3'd5;
   localparam logic [2:0] c_t_current    = 3'd6;
   localparam logic [2:0] c_t_invalid    = 3'd7;

   // RGB332 palette.
   localparam logic [7:0] c_col_unvisited  = 8'hFF;
   localparam logic [7:0] c_col_visited    = 8'hFC;
   localparam logic [7:0] c_col_wall       = 8'h88;
   localparam logic [7:0] c_col_treasure7  = 8'hE0;
   localparam logic [7:0] c_col_treasure12 = 8'h1C;
   localparam logic [7:0] c_col_treasure17 = 8'h03;
   localparam logic [7:0] c_col_current    = 8'h3E;
   localparam logic [7:0] c_col_invalid    = 8'h00;

   typedef enum logic [2:0] {
      S_SWEEP   = 3'd0,
      S_IDLE    = 3'd1,
      S_CHECK   = 3'd2,
      S_WR_PREV = 3'd3,
      S_WR_TILE = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/maze_type_decode.sv
// ============================================================================
// maze_type_decode : tile type to RGB332 colour, plus row-range / invalid-type
//                    check and treasure classification (purely combinational).
// Revision         : 1.0
// ============================================================================
`default_nettype none

module maze_type_decode
   import maze_pkg::*;
#(
   parameter int GRID_H = c_grid_h_def
) (
   input  logic [2:0] type_i,
   input  logic [2:0] y_i,
   output logic [7:0] color_o,
   output logic       invalid_o,
   output logic       treasure_o
);

   always_comb begin
      color_o = c_col_invalid;
      case (type_i)
         c_t_unvisited:  color_o = c_col_unvisited;
         c_t_visited:    color_o = c_col_visited;
         c_t_wall:       color_o = c_col_wall;
         c_t_treasure7:  color_o = c_col_treasure7;
         c_t_treasure12: color_o = c_col_treasure12;
         c_t_treasure17: color_o = c_col_treasure17;
         c_t_current:    color_o = c_col_current;
         default:        color_o = c_col_invalid;
      endcase
   end

   assign invalid_o  = (type_i == c_t_invalid) || (int'(y_i) >= GRID_H);
   assign treasure_o = (type_i == c_t_treasure7) || (type_i == c_t_treasure12) ||
                       (type_i == c_t_treasure17);

endmodule

`default_nettype wire

// File: rtl/maze_map_ctrl.sv
// ============================================================================
// maze_map_ctrl : sequences all writes into the maze tile store (init sweep,
//                 validated robot packets, current-tile demotion, treasures).
//                 Optional macro TEAR_FREE_EN restricts writes to V_BLANK.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module maze_map_ctrl
   import maze_pkg::*;
#(
   parameter int GRID_W = c_grid_w_def,
   parameter int GRID_H = c_grid_h_def,
   parameter int ERR_W  = 4
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [15:0]      PKT_IN,
   input  logic             PKT_VALID,
   output logic             PKT_READY,
   input  logic             CLEAR,
   input  logic             V_BLANK,
   output logic             WR_EN,
   output logic [1:0]       WR_X,
   output logic [2:0]       WR_Y,
   output logic [7:0]       WR_COLOR,
   output logic [3:0]       WR_WALLS,
   output logic [1:0]       CUR_X,
   output logic [2:0]       CUR_Y,
   output logic             CUR_VALID,
   output logic [4:0]       TREASURE_COUNT,
   output logic [ERR_W-1:0] ERR_COUNT,
   output logic             BUSY
);

   localparam int NT     = GRID_W * GRID_H;
   localparam int TIDX_W = $clog2(NT);
   localparam logic [1:0] LAST_X = 2'(GRID_W - 1);
   localparam logic [2:0] LAST_Y = 3'(GRID_H - 1);

   state_e            state_q, state_d;
   logic [11:0]       pkt_q, pkt_d, last_q, last_d;
   logic              last_vld_q, last_vld_d, clr_pend_q, clr_pend_d;
   logic [1:0]        sx_q, sx_d;
   logic [2:0]        sy_q, sy_d;
   logic              sdone_q, sdone_d;
   logic              wr_en_q, wr_en_d;
   logic [1:0]        wr_x_q, wr_x_d, cur_x_q, cur_x_d;
   logic [2:0]        wr_y_q, wr_y_d, cur_y_q, cur_y_d;
   logic [7:0]        wr_col_q, wr_col_d;
   logic [3:0]        wr_walls_q, wr_walls_d, cur_walls_q, cur_walls_d;
   logic              cur_vld_q, cur_vld_d;
   logic [4:0]        treas_q, treas_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [NT-1:0]     tflag_q, tflag_d;

   logic              w_go, w_unused;
   logic [1:0]        w_px;
   logic [2:0]        w_py, w_pt;
   logic [3:0]        w_pw;
   logic [7:0]        w_color;
   logic              w_bad, w_treasure;
   logic [TIDX_W-1:0] w_tidx;

   // pkt_q holds packet bits [15:4]; reserved bits are never stored.
   assign w_px   = pkt_q[c_pkt_x_lsb-c_pkt_w_lsb +: 2];
   assign w_py   = pkt_q[c_pkt_y_lsb-c_pkt_w_lsb +: 3];
   assign w_pt   = pkt_q[c_pkt_t_lsb-c_pkt_w_lsb +: 3];
   assign w_pw   = pkt_q[3:0];
   assign w_tidx = TIDX_W'(int'(w_py) * GRID_W + int'(w_px));

`ifdef TEAR_FREE_EN
   assign w_go     = V_BLANK;
   assign w_unused = ^PKT_IN[3:0];
`else
   assign w_go     = 1'b1;
   assign w_unused = ^{PKT_IN[3:0], V_BLANK};
`endif

   maze_type_decode #(.GRID_H(GRID_H)) u_decode (
      .type_i     (w_pt),
      .y_i        (w_py),
      .color_o    (w_color),
      .invalid_o  (w_bad),
      .treasure_o (w_treasure)
   );

   always_comb begin
      state_d     = state_q;
      pkt_d       = pkt_q;
      last_d      = last_q;
      last_vld_d  = last_vld_q;
      clr_pend_d  = clr_pend_q | CLEAR;
      sx_d        = sx_q;
      sy_d        = sy_q;
      sdone_d     = sdone_q;
      wr_en_d     = wr_en_q;
      wr_x_d      = wr_x_q;
      wr_y_d      = wr_y_q;
      wr_col_d    = wr_col_q;
      wr_walls_d  = wr_walls_q;
      cur_x_d     = cur_x_q;
      cur_y_d     = cur_y_q;
      cur_walls_d = cur_walls_q;
      cur_vld_d   = cur_vld_q;
      treas_d     = treas_q;
      err_d       = err_q;
      tflag_d     = tflag_q;

      case (state_q)
         // Writes are registered: a tile loaded here is on WR_* next cycle,
         // so a still-undelivered write (no blanking) stalls the sweep.
         S_SWEEP: begin
            if (!(wr_en_q && !w_go)) begin
               wr_en_d = 1'b0;
               if (!sdone_q) begin
                  wr_en_d    = 1'b1;
                  wr_x_d     = sx_q;
                  wr_y_d     = sy_q;
                  wr_col_d   = c_col_unvisited;
                  wr_walls_d = 4'b0000;
                  if (sx_q == LAST_X) begin
                     sx_d = 2'd0;
                     if (sy_q == LAST_Y) sdone_d = 1'b1;
                     else                sy_d    = sy_q + 3'd1;
                  end else begin
                     sx_d = sx_q + 2'd1;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_IDLE: begin
            if (clr_pend_q || CLEAR) begin
               clr_pend_d = 1'b0;
               state_d    = S_SWEEP;
               sx_d       = 2'd0;
               sy_d       = 3'd0;
               sdone_d    = 1'b0;
               cur_vld_d  = 1'b0;
               treas_d    = 5'd0;
               err_d      = '0;
               tflag_d    = '0;
               last_d     = 12'd0;
               last_vld_d = 1'b0;
            end else if (PKT_VALID) begin
               pkt_d   = PKT_IN[15:4];
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_bad) begin
               err_d   = (&err_q) ? err_q : err_q + ERR_W'(1);
               state_d = S_IDLE;
            end else if (last_vld_q && (pkt_q == last_q)) begin
               state_d = S_IDLE;
            end else if ((w_pt == c_t_current) && cur_vld_q &&
                         ((w_px != cur_x_q) || (w_py != cur_y_q))) begin
               wr_en_d    = 1'b1;
               wr_x_d     = cur_x_q;
               wr_y_d     = cur_y_q;
               wr_col_d   = c_col_visited;
               wr_walls_d = cur_walls_q;
               state_d    = S_WR_PREV;
            end else begin
               wr_en_d    = 1'b1;
               wr_x_d     = w_px;
               wr_y_d     = w_py;
               wr_col_d   = w_color;
               wr_walls_d = w_pw;
               state_d    = S_WR_TILE;
            end
         end
         S_WR_PREV: begin
            if (w_go) begin
               wr_en_d    = 1'b1;
               wr_x_d     = w_px;
               wr_y_d     = w_py;
               wr_col_d   = w_color;
               wr_walls_d = w_pw;
               state_d    = S_WR_TILE;
            end
         end
         S_WR_TILE: begin
            if (w_go) begin
               wr_en_d    = 1'b0;
               state_d    = S_IDLE;
               last_d     = pkt_q;
               last_vld_d = 1'b1;
               if (w_pt == c_t_current) begin
                  cur_x_d     = w_px;
                  cur_y_d     = w_py;
                  cur_walls_d = w_pw;
                  cur_vld_d   = 1'b1;
               end
               if (w_treasure && !tflag_q[w_tidx]) begin
                  tflag_d[w_tidx] = 1'b1;
                  treas_d         = treas_q + 5'd1;
               end
            end
         end
         default: state_d = S_SWEEP;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= S_SWEEP;
         pkt_q       <= 12'd0;
         last_q      <= 12'd0;
         last_vld_q  <= 1'b0;
         clr_pend_q  <= 1'b0;
         sx_q        <= 2'd0;
         sy_q        <= 3'd0;
         sdone_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_x_q      <= 2'd0;
         wr_y_q      <= 3'd0;
         wr_col_q    <= 8'd0;
         wr_walls_q  <= 4'd0;
         cur_x_q     <= 2'd0;
         cur_y_q     <= 3'd0;
         cur_walls_q <= 4'd0;
         cur_vld_q   <= 1'b0;
         treas_q     <= 5'd0;
         err_q       <= '0;
         tflag_q     <= '0;
      end else begin
         state_q     <= state_d;
         pkt_q       <= pkt_d;
         last_q      <= last_d;
         last_vld_q  <= last_vld_d;
         clr_pend_q  <= clr_pend_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         sdone_q     <= sdone_d;
         wr_en_q     <= wr_en_d;
         wr_x_q      <= wr_x_d;
         wr_y_q      <= wr_y_d;
         wr_col_q    <= wr_col_d;
         wr_walls_q  <= wr_walls_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         cur_walls_q <= cur_walls_d;
         cur_vld_q   <= cur_vld_d;
         treas_q     <= treas_d;
         err_q       <= err_d;
         tflag_q     <= tflag_d;
      end
   end

   assign PKT_READY      = (state_q == S_IDLE) && !clr_pend_q && !CLEAR;
   assign BUSY           = (state_q != S_IDLE);
   assign WR_EN          = wr_en_q & w_go;
   assign WR_X           = wr_x_q;
   assign WR_Y           = wr_y_q;
   assign WR_COLOR       = wr_col_q;
   assign WR_WALLS       = wr_walls_q;
   assign CUR_X          = cur_x_q;
   assign CUR_Y          = cur_y_q;
   assign CUR_VALID      = cur_vld_q;
   assign TREASURE_COUNT = treas_q;
   assign ERR_COUNT      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_map_ctrl.sv
// ============================================================================
// tb_maze_map_ctrl : directed self-checking bench for maze_map_ctrl.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_maze_map_ctrl;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [15:0] PKT_IN = 16'h0000;
   logic        PKT_VALID = 1'b0;
   logic        CLEAR = 1'b0;
   logic        V_BLANK = 1'b1;
   logic        PKT_READY, WR_EN, CUR_VALID, BUSY;
   logic [1:0]  WR_X, CUR_X;
   logic [2:0]  WR_Y, CUR_Y;
   logic [7:0]  WR_COLOR;
   logic [3:0]  WR_WALLS, ERR_COUNT;
   logic [4:0]  TREASURE_COUNT;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int         cyc;
      logic [1:0] x;
      logic [2:0] y;
      logic [7:0] c;
      logic [3:0] w;
   } wr_t;
   wr_t wlog[$];

   maze_map_ctrl dut (
      .CLOCK(CLOCK), .RESET(RESET), .PKT_IN(PKT_IN), .PKT_VALID(PKT_VALID),
      .PKT_READY(PKT_READY), .CLEAR(CLEAR), .V_BLANK(V_BLANK), .WR_EN(WR_EN),
      .WR_X(WR_X), .WR_Y(WR_Y), .WR_COLOR(WR_COLOR), .WR_WALLS(WR_WALLS),
      .CUR_X(CUR_X), .CUR_Y(CUR_Y), .CUR_VALID(CUR_VALID),
      .TREASURE_COUNT(TREASURE_COUNT), .ERR_COUNT(ERR_COUNT), .BUSY(BUSY)
   );

   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc <= cyc + 1;

   always @(negedge CLOCK) begin
      if (WR_EN === 1'b1) wlog.push_back('{cyc, WR_X, WR_Y, WR_COLOR, WR_WALLS});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input int idx, input int ecyc,
                         input logic [1:0] ex, input logic [2:0] ey,
                         input logic [7:0] ec, input logic [3:0] ew);
      if (idx >= wlog.size()) begin
         chk({tag, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
      end else begin
         chk({tag, "_cyc"}, 32'(wlog[idx].cyc), 32'(ecyc));
         chk({tag, "_xycw"}, {13'd0, wlog[idx].x, wlog[idx].y, wlog[idx].c, wlog[idx].w},
             {13'd0, ex, ey, ec, ew});
      end
   endtask

   // Drive a packet from a negedge; returns the edge count after the transfer.
   task automatic send(input logic [15:0] p, output int xfer);
      int k;
      PKT_IN    = p;
      PKT_VALID = 1'b1;
      k = 0;
      while (PKT_READY !== 1'b1 && k < 100) begin
         @(negedge CLOCK);
         k++;
      end
      xfer = cyc + 1;
      chk("send_ready", {31'd0, PKT_READY}, 32'd1);
      @(negedge CLOCK);
      PKT_VALID = 1'b0;
   endtask

   task automatic wait_ready(output int rcyc);
      int k;
      k = 0;
      while (PKT_READY !== 1'b1 && k < 100) begin
         @(negedge CLOCK);
         k++;
      end
      rcyc = cyc;
      chk("wait_ready", {31'd0, PKT_READY}, 32'd1);
   endtask

   task automatic chk_sweep(input int base);
      for (int i = 0; i < 20; i++) begin
         if (base + i < wlog.size()) begin
            chk("sweep_xycw",
                {13'd0, wlog[base+i].x, wlog[base+i].y, wlog[base+i].c, wlog[base+i].w},
                {13'd0, 2'(i % 4), 3'(i / 4), 8'hFF, 4'h0});
            chk("sweep_cyc", 32'(wlog[base+i].cyc), 32'(wlog[base].cyc + i));
         end
      end
   endtask

   initial begin
      int xf, xf2, rc;
      repeat (3) @(negedge CLOCK);
      chk("rst_wr_en",     {31'd0, WR_EN}, 32'd0);
      chk("rst_ready",     {31'd0, PKT_READY}, 32'd0);
      chk("rst_cur_valid", {31'd0, CUR_VALID}, 32'd0);
      chk("rst_treasure",  {27'd0, TREASURE_COUNT}, 32'd0);
      chk("rst_err",       {28'd0, ERR_COUNT}, 32'd0);
      wlog.delete();

      // 1: initial sweep
      RESET = 1'b0;
      @(negedge CLOCK);
      chk("sweep_busy", {31'd0, BUSY}, 32'd1);
      wait_ready(rc);
      chk("sweep_count", 32'(wlog.size()), 32'd20);
      chk_sweep(0);
      if (wlog.size() > 0) chk("ready_after_sweep", 32'(rc), 32'(wlog[wlog.size()-1].cyc + 1));
      chk("idle_busy", {31'd0, BUSY}, 32'd0);

      // 2: plain visited tile
      wlog.delete();
      send(16'h8960, xf);
      repeat (4) @(negedge CLOCK);
      chk("t2_count", 32'(wlog.size()), 32'd1);
      chk_wr("t2", 0, xf + 1, 2'd2, 3'd1, 8'hFC, 4'b0110);

      // 3: current tile moves, previous demoted
      wlog.delete();
      send(16'h0600, xf);
      repeat (4) @(negedge CLOCK);
      chk_wr("t3a", 0, xf + 1, 2'd0, 3'd0, 8'h3E, 4'b0000);
      wlog.delete();
      send(16'h4610, xf);
      repeat (5) @(negedge CLOCK);
      chk("t3b_count", 32'(wlog.size()), 32'd2);
      chk_wr("t3b_prev", 0, xf + 1, 2'd0, 3'd0, 8'hFC, 4'b0000);
      chk_wr("t3b_tile", 1, xf + 2, 2'd1, 3'd0, 8'h3E, 4'b0001);
      chk("t3_cur", {27'd0, CUR_VALID, CUR_X, CUR_Y}, {27'd0, 1'b1, 2'd1, 3'd0});
      // current re-reported at the same tile: no demotion write
      wlog.delete();
      send(16'h4600, xf);
      repeat (5) @(negedge CLOCK);
      chk("t3c_count", 32'(wlog.size()), 32'd1);
      chk_wr("t3c_tile", 0, xf + 1, 2'd1, 3'd0, 8'h3E, 4'b0000);

      // 4: invalid packets and error saturation
      wlog.delete();
      send(16'h2900, xf);
      send(16'h0700, xf);
      repeat (4) @(negedge CLOCK);
      chk("t4_nowrite", 32'(wlog.size()), 32'd0);
      chk("t4_err2", {28'd0, ERR_COUNT}, 32'd2);
      for (int i = 0; i < 20; i++) send(16'h0700, xf);
      repeat (4) @(negedge CLOCK);
      chk("t4_err_sat", {28'd0, ERR_COUNT}, 32'd15);
      chk("t4_nowrite2", 32'(wlog.size()), 32'd0);

      // 5: treasures at (3,4)
      wlog.delete();
      send(16'hE300, xf);
      send(16'hE300, xf2);
      repeat (4) @(negedge CLOCK);
      chk("t5_dup_count", 32'(wlog.size()), 32'd1);
      chk_wr("t5a", 0, xf + 1, 2'd3, 3'd4, 8'hE0, 4'b0000);
      chk("t5_treasure1", {27'd0, TREASURE_COUNT}, 32'd1);
      wlog.delete();
      send(16'hE480, xf);
      repeat (4) @(negedge CLOCK);
      chk_wr("t5b", 0, xf + 1, 2'd3, 3'd4, 8'h1C, 4'b1000);
      chk("t5_treasure_hold", {27'd0, TREASURE_COUNT}, 32'd1);

      // 6: CLEAR during CHECK lets the packet finish, then re-sweeps
      wlog.delete();
      send(16'h8920, xf);
      CLEAR = 1'b1;
      @(negedge CLOCK);
      CLEAR = 1'b0;
      @(negedge CLOCK);
      chk("t6_ready_low_pending", {31'd0, PKT_READY}, 32'd0);
      wait_ready(rc);
      chk("t6_count", 32'(wlog.size()), 32'd21);
      chk_wr("t6_pkt", 0, xf + 1, 2'd2, 3'd1, 8'hFC, 4'b0010);
      chk_sweep(1);
      chk("t6_cleared", {18'd0, CUR_VALID, TREASURE_COUNT, ERR_COUNT}, 32'd0);

      // CLEAR beats a simultaneous packet in IDLE
      wlog.delete();
      PKT_IN    = 16'h8960;
      PKT_VALID = 1'b1;
      CLEAR     = 1'b1;
      #1;
      chk("t7_ready_vs_clear", {31'd0, PKT_READY}, 32'd0);
      @(negedge CLOCK);
      CLEAR     = 1'b0;
      PKT_VALID = 1'b0;
      wait_ready(rc);
      chk("t7_count", 32'(wlog.size()), 32'd20);
      chk_sweep(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
